sketch_sense_ctrl: RTL and testbench
====================================

# sketch_sense_ctrl

Sequencer that drives the sketch-sensing pipeline (sparse threshold stage followed by chained column-compress stages) from the sketch counter memory. On a start command it streams every counter of each sketch row into the pipeline and waits for the pipeline to drain. It then captures the pipeline's 1-bit result for that row and clears the pipeline before the next row. It sits between the sketch counter RAM (read side) and the sensing pipeline, and reports a per-row flag vector to the host.

## Interface

**Parameters**
- `NUM_COUNTER`, default 10: counters per sketch row.
- `NUM_ROW`, default 4: rows sensed per command; range 1..32.
- `PIPE_LAT`, default 4: cycles from the last `Pipe_Valid` until `Pipe_Result` is stable.
- `ADDR_W`, default 8: counter memory address width.

**Ports**
- `Clk`  in  1  system clock. One clock domain only.
- `Reset`  in  1  asynchronous reset, active-high.
- `Start`  in  1  single-cycle command pulse; accepted only in IDLE.
- `Abort`  in  1  terminates a running command.
- `Base_Addr`  in  ADDR_W  address of counter 0 of row 0; latched on an accepted `Start`.
- `Mem_Rd`  out  1  memory read strobe.
- `Mem_Addr`  out  ADDR_W  memory read address.
- `Mem_Data`  in  32  read data, valid exactly 1 cycle after `Mem_Rd`.
- `Pipe_Counter`  out  32  counter value presented to the pipeline.
- `Pipe_Valid`  out  1  `Pipe_Counter` is valid this cycle.
- `Pipe_Clear`  out  1  synchronous clear of the pipeline state.
- `Pipe_Result`  in  1  pipeline sensing result.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  1-cycle pulse when all rows have completed.
- `Row_Flags`  out  NUM_ROW  captured `Pipe_Result` for each row.

## Operation

- **Reset values:** all outputs are 0; state is IDLE.
- **States:** IDLE, FETCH, DRAIN, CLEAR, DONE.
- **IDLE:**
  - `Start` & !`Abort` → FETCH.
  - Latch `Base_Addr`, zero `Row_Flags`, row=0, idx=0.
- **FETCH:**
  - `Mem_Rd`=1 and `Mem_Addr` = base + row·NUM_COUNTER + idx. The sum is truncated to ADDR_W bits, so addresses wrap modulo 2^ADDR_W.
  - idx increments each cycle. After idx = NUM_COUNTER−1, go to DRAIN.
  - Exactly NUM_COUNTER reads are issued per row, back-to-back, with no gaps.
- **Data path:**
  - `Pipe_Valid` is `Mem_Rd` delayed by 2 cycles.
  - `Pipe_Counter` is `Mem_Data` registered on the cycle after the read.
  - `Pipe_Counter` holds its last value when `Pipe_Valid`=0.
- **DRAIN:**
  - Lasts PIPE_LAT+2 cycles: 2 cycles flush the read/register stages, then PIPE_LAT cycles for the pipeline.
  - On the last DRAIN cycle, `Row_Flags[row]` ← `Pipe_Result`. Then go to CLEAR.
- **CLEAR:**
  - `Pipe_Clear`=1 for 1 cycle.
  - If row = NUM_ROW−1 → DONE. Otherwise row++, idx=0 → FETCH.
- **DONE:** `Done`=1 for 1 cycle, then → IDLE. `Row_Flags` holds until the next accepted `Start`.
- **Abort:**
  - `Abort` in FETCH, DRAIN or DONE → CLEAR, then IDLE. `Done` is not asserted.
  - Reads already in flight are discarded: `Pipe_Valid` is forced to 0 from the abort cycle onward.
  - `Row_Flags` keeps the rows that completed; the current and later rows read 0.
  - `Abort` during CLEAR finishes that CLEAR, then → IDLE.
  - `Abort` in IDLE has no effect.
- **Simultaneous and ignored inputs:**
  - `Start` & `Abort` in IDLE: `Abort` wins and the command is not accepted.
  - `Start` while `Busy`: ignored. It is not queued.
- **Reset mid-command:** immediate return to IDLE with all outputs 0. The pipeline is not cleared by this block.

## Timing

- `Start` sampled at edge k → FETCH from cycle k+1. First `Mem_Rd` at k+1; first `Pipe_Valid` at k+3.
- Per row: NUM_COUNTER + PIPE_LAT + 3 cycles.
- `Done` occurs at cycle k+1+NUM_ROW·(NUM_COUNTER+PIPE_LAT+3). With defaults this is k+69; each row takes 17 cycles.
- `Busy` rises at k+1 and falls in the cycle after `Done`.
- `Row_Flags[r]` is updated on the edge that ends row r's DRAIN and is visible in CLEAR.
- No combinational path from any input to any output. All outputs are registered.

## Structure

- **Shared package `sketch_sense_pkg`:**
  - state enum (IDLE/FETCH/DRAIN/CLEAR/DONE);
  - the read-latency constant (1);
  - the 32-bit counter width.
- **Counter widths:** the idx, row and drain counters are sized with `$clog2` of their bounds, with a minimum width of 1.
- **Sub-module:** one is natural: `sense_addr_gen`, which produces the base + row·NUM_COUNTER + idx address. It keeps a running row offset by accumulating NUM_COUNTER per row instead of multiplying.
- **Remainder:** FSM plus the two-stage valid/data delay line.

## Test plan

- **Basic command:** defaults, `Base_Addr`=0x10, memory word = address, `Pipe_Result` model = 1 for rows 1 and 3.
  - Expect `Mem_Addr` 0x10..0x37 in four bursts of 10.
  - Expect `Done` at k+69 and `Row_Flags`=4'b1010.
- **Address wrap:** `Base_Addr`=0xF8, ADDR_W=8.
  - Row 0 addresses are 0xF8..0xFF, then 0x00, 0x01; row 1 starts at 0x02.
- **Abort mid-row:** `Abort` on the 5th FETCH cycle of row 2.
  - Expect `Pipe_Valid` low from that cycle, one `Pipe_Clear`, then IDLE.
  - Expect no `Done` and `Row_Flags[3:2]`=0, with rows 0–1 retained.
- **Start collisions:**
  - `Start`+`Abort` together in IDLE → stays IDLE, no `Mem_Rd`.
  - `Start` pulsed at k+20 while busy → no effect; `Done` still at k+69.
- **Reset mid-DRAIN:** `Reset` asserted mid-DRAIN of row 1.
  - Expect all outputs 0 asynchronously.
  - A new `Start` afterwards behaves exactly as the basic command.
- **Single-row configuration:** NUM_ROW=1, NUM_COUNTER=1, PIPE_LAT=0.
  - Expect `Done` at k+5 and exactly one `Pipe_Valid` at k+3.

Source files
------------

// File: rtl/sketch_sense_pkg.sv
// Shared definitions for the sketch-sensing sequencer: FSM states, memory read
// latency and counter width.
package sketch_sense_pkg;

    localparam int unsigned RD_LAT = 1;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_CLEAR,
        ST_DONE
    } sense_state_e;

    // Counter width for a bound, never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned bound);
        return (bound > 1) ? int'($clog2(bound)) : 1;
    endfunction

endpackage

// File: rtl/sense_addr_gen.sv
// Read-address generator: base + row offset + index. The row offset is
// accumulated one row at a time, so no multiplier is needed.
module sense_addr_gen
    import sketch_sense_pkg::*;
#(
    parameter int NUM_COUNTER = 10,
    parameter int ADDR_W      = 8,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              row_adv_i,
    input  logic              fetch_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [ADDR_W-1:0] addr_o
);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(NUM_COUNTER);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] row_off_q, row_off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Address is registered from next-state values so it lines up with the read strobe.
    always_comb begin
        base_d    = load_i ? base_i : base_q;
        row_off_d = row_off_q;
        if (load_i) begin
            row_off_d = '0;
        end else if (row_adv_i) begin
            row_off_d = row_off_q + ROW_STEP;
        end
        addr_d = addr_q;
        if (fetch_i) begin
            addr_d = base_d + row_off_d + ADDR_W'(idx_i);
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q    <= '0;
            row_off_q <= '0;
            addr_q    <= '0;
        end else begin
            base_q    <= base_d;
            row_off_q <= row_off_d;
            addr_q    <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/sketch_sense_ctrl.sv
// Sequencer streaming each sketch row from counter memory into the sensing
// pipeline, capturing one result bit per row.
module sketch_sense_ctrl
    import sketch_sense_pkg::*;
#(
    parameter int NUM_COUNTER = 10,
    parameter int NUM_ROW     = 4,
    parameter int PIPE_LAT    = 4,
    parameter int ADDR_W      = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Abort,
    input  logic [ADDR_W-1:0]  Base_Addr,
    output logic               Mem_Rd,
    output logic [ADDR_W-1:0]  Mem_Addr,
    input  logic [CNT_W-1:0]   Mem_Data,
    output logic [CNT_W-1:0]   Pipe_Counter,
    output logic               Pipe_Valid,
    output logic               Pipe_Clear,
    input  logic               Pipe_Result,
    output logic               Busy,
    output logic               Done,
    output logic [NUM_ROW-1:0] Row_Flags
);

    localparam int DRAIN_CYC = PIPE_LAT + RD_LAT + 1;
    localparam int IDX_W     = width_of(NUM_COUNTER);
    localparam int ROW_W     = width_of(NUM_ROW);
    localparam int DRN_W     = width_of(DRAIN_CYC);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_COUNTER - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROW - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC - 1);

    sense_state_e       state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic [NUM_ROW-1:0] flags_q, flags_d;
    logic               aborted_q, aborted_d;
    logic               load, row_adv, kill;

    logic               rd_dly_q;
    logic               valid_q;
    logic [CNT_W-1:0]   counter_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        row_d     = row_q;
        drain_d   = drain_q;
        flags_d   = flags_q;
        aborted_d = aborted_q;
        load      = 1'b0;
        row_adv   = 1'b0;
        kill      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                aborted_d = 1'b0;
                if (Start && !Abort) begin
                    state_d = ST_FETCH;
                    load    = 1'b1;
                    flags_d = '0;
                    row_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_FETCH: begin
                if (Abort) begin
                    kill      = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = ST_CLEAR;
                end else if (idx_q == IDX_LAST) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (Abort) begin
                    kill      = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = ST_CLEAR;
                end else if (drain_q == DRN_LAST) begin
                    flags_d[row_q] = Pipe_Result;
                    state_d        = ST_CLEAR;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_CLEAR: begin
                if (aborted_q || Abort) begin
                    state_d = ST_IDLE;
                end else if (row_q == ROW_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + 1'b1;
                    idx_d   = '0;
                    row_adv = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                if (Abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            row_q     <= '0;
            drain_q   <= '0;
            flags_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            row_q     <= row_d;
            drain_q   <= drain_d;
            flags_q   <= flags_d;
            aborted_q <= aborted_d;
        end
    end

    // Read strobe -> data register -> valid; an abort squashes reads still in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_dly_q  <= 1'b0;
            valid_q   <= 1'b0;
            counter_q <= '0;
        end else begin
            rd_dly_q <= Mem_Rd && !kill;
            valid_q  <= rd_dly_q && !kill;
            if (rd_dly_q && !kill) begin
                counter_q <= Mem_Data;
            end
        end
    end

    sense_addr_gen #(
        .NUM_COUNTER (NUM_COUNTER),
        .ADDR_W      (ADDR_W),
        .IDX_W       (IDX_W)
    ) u_addr_gen (
        .clk       (Clk),
        .rst       (Reset),
        .load_i    (load),
        .base_i    (Base_Addr),
        .row_adv_i (row_adv),
        .fetch_i   (state_d == ST_FETCH),
        .idx_i     (idx_d),
        .addr_o    (Mem_Addr)
    );

    assign Mem_Rd       = (state_q == ST_FETCH);
    assign Pipe_Clear   = (state_q == ST_CLEAR);
    assign Done         = (state_q == ST_DONE);
    assign Busy         = (state_q != ST_IDLE);
    assign Pipe_Valid   = valid_q;
    assign Pipe_Counter = counter_q;
    assign Row_Flags    = flags_q;

endmodule

// File: tb/tb_sketch_sense_ctrl.sv
// Self-checking bench for sketch_sense_ctrl: a memory model, a pipeline model
// that only settles once a full row has streamed in, and a cycle-level reference.
module tb_sketch_sense_ctrl;

    localparam int NC      = 10;
    localparam int NR      = 4;
    localparam int PL      = 4;
    localparam int AW      = 8;
    localparam int ROW_CYC = NC + PL + 3;
    localparam int CMD_CYC = NR * ROW_CYC;
    localparam int WIN     = CMD_CYC + 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort;
    logic [AW-1:0] base_addr;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic [31:0]   pipe_counter;
    logic          pipe_valid, pipe_clear, pipe_result, busy, done;
    logic [NR-1:0] row_flags;

    logic          b_start, b_abort;
    logic [AW-1:0] b_base;
    logic          b_mem_rd;
    logic [AW-1:0] b_mem_addr;
    logic [31:0]   b_mem_data;
    logic [31:0]   b_pipe_counter;
    logic          b_pipe_valid, b_pipe_clear, b_pipe_result, b_busy, b_done;
    logic [0:0]    b_row_flags;

    logic [31:0]   mem [256];
    logic [3:0]    pat;
    logic          pm_restart;
    int            pm_beats, pm_since, pm_rows;
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    sketch_sense_ctrl #(.NUM_COUNTER(NC), .NUM_ROW(NR), .PIPE_LAT(PL), .ADDR_W(AW)) u_dut (
        .Clk(clk), .Reset(rst), .Start(start), .Abort(abort), .Base_Addr(base_addr),
        .Mem_Rd(mem_rd), .Mem_Addr(mem_addr), .Mem_Data(mem_data),
        .Pipe_Counter(pipe_counter), .Pipe_Valid(pipe_valid), .Pipe_Clear(pipe_clear),
        .Pipe_Result(pipe_result), .Busy(busy), .Done(done), .Row_Flags(row_flags)
    );

    sketch_sense_ctrl #(.NUM_COUNTER(1), .NUM_ROW(1), .PIPE_LAT(0), .ADDR_W(AW)) u_dut_b (
        .Clk(clk), .Reset(rst), .Start(b_start), .Abort(b_abort), .Base_Addr(b_base),
        .Mem_Rd(b_mem_rd), .Mem_Addr(b_mem_addr), .Mem_Data(b_mem_data),
        .Pipe_Counter(b_pipe_counter), .Pipe_Valid(b_pipe_valid), .Pipe_Clear(b_pipe_clear),
        .Pipe_Result(b_pipe_result), .Busy(b_busy), .Done(b_done), .Row_Flags(b_row_flags)
    );

    // Memory returns data exactly one cycle after a read, garbage otherwise.
    always @(posedge clk) begin
        mem_data   <= mem_rd   ? mem[mem_addr]   : $urandom;
        b_mem_data <= b_mem_rd ? mem[b_mem_addr] : $urandom;
    end

    // Pipeline model: result is the row's pattern bit only after NC beats and PL settle cycles.
    always @(posedge clk) begin
        if (rst || pm_restart) begin
            pm_beats <= 0;
            pm_since <= 0;
            pm_rows  <= 0;
        end else if (pipe_clear) begin
            pm_beats <= 0;
            pm_since <= 0;
            pm_rows  <= pm_rows + 1;
        end else if (pipe_valid) begin
            pm_beats <= pm_beats + 1;
            pm_since <= 1;
        end else begin
            pm_since <= pm_since + 1;
        end
    end

    logic pm_full, pm_settled;
    assign pm_full     = (pm_beats + int'(pipe_valid)) == NC;
    assign pm_settled  = pipe_valid ? (PL == 0) : (pm_since >= PL);
    assign pipe_result = pat[pm_rows[1:0]] ^ !(pm_full && pm_settled);

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill_mem(input bit identity);
        for (int a = 0; a < 256; a++) mem[a] = identity ? 32'(a) : $urandom;
    endtask

    // Reference for the main instance at cycle rel (rel=1 is the first cycle after Start is taken).
    task automatic compare_cycle(input logic [AW-1:0] base, input int rel, input int abort_rel);
        int            row, ph;
        bit            live;
        logic          e_rd, e_pv, e_clr, e_done, e_busy;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_pc;
        logic [NR-1:0] e_flags;
        row    = (rel - 1) / ROW_CYC;
        ph     = (rel - 1) % ROW_CYC;
        live   = (rel <= CMD_CYC) && (abort_rel == 0 || rel <= abort_rel);
        e_rd   = live && ph < NC;
        e_addr = AW'(int'(base) + row * NC + ph);
        e_pv   = live && ph >= 2 && ph <= NC + 1;
        e_pc   = mem[AW'(int'(base) + row * NC + ph - 2)];
        e_clr  = (live && ph == ROW_CYC - 1) || (abort_rel != 0 && rel == abort_rel + 1);
        e_done = (abort_rel == 0) && (rel == CMD_CYC + 1);
        e_busy = (abort_rel == 0) ? (rel <= CMD_CYC + 1) : (rel <= abort_rel + 1);
        e_flags = '0;
        for (int r = 0; r < NR; r++) begin
            if (rel >= (r + 1) * ROW_CYC && (abort_rel == 0 || (r + 1) * ROW_CYC <= abort_rel))
                e_flags[r] = pat[r];
        end
        check($sformatf("mem_rd@%0d", rel), mem_rd, e_rd);
        if (e_rd) check($sformatf("mem_addr@%0d", rel), mem_addr, e_addr);
        check($sformatf("pipe_valid@%0d", rel), pipe_valid, e_pv);
        if (e_pv) check($sformatf("pipe_counter@%0d", rel), pipe_counter, e_pc);
        check($sformatf("pipe_clear@%0d", rel), pipe_clear, e_clr);
        check($sformatf("done@%0d", rel), done, e_done);
        check($sformatf("busy@%0d", rel), busy, e_busy);
        check($sformatf("row_flags@%0d", rel), row_flags, e_flags);
    endtask

    task automatic run_cmd(input logic [AW-1:0] base, input int abort_rel,
                           input int collide_rel, input int reset_rel);
        int last;
        last = (reset_rel > 0) ? reset_rel : WIN;
        base_addr  = base;
        start      = 1'b1;
        pm_restart = 1'b1;
        for (int rel = 1; rel <= last; rel++) begin
            tick();
            compare_cycle(base, rel, abort_rel);
            pm_restart = 1'b0;
            start      = (rel == collide_rel);
            abort      = (rel == abort_rel);
            base_addr  = AW'($urandom);
        end
        start = 1'b0;
        abort = 1'b0;
        if (reset_rel > 0) begin
            #2 rst = 1'b1;
            #1;
            check("rst_mem_rd", mem_rd, 1'b0);
            check("rst_mem_addr", mem_addr, '0);
            check("rst_pipe_counter", pipe_counter, '0);
            check("rst_pipe_valid", pipe_valid, 1'b0);
            check("rst_pipe_clear", pipe_clear, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_row_flags", row_flags, '0);
            tick();
            rst = 1'b0;
        end
        tick();
    endtask

    task automatic run_single(input logic res);
        logic [AW-1:0] base;
        base          = AW'($urandom);
        b_base        = base;
        b_pipe_result = res;
        b_start       = 1'b1;
        for (int rel = 1; rel <= 8; rel++) begin
            tick();
            b_start = 1'b0;
            b_base  = AW'($urandom);
            check($sformatf("b_mem_rd@%0d", rel), b_mem_rd, rel == 1);
            if (rel == 1) check("b_mem_addr", b_mem_addr, base);
            check($sformatf("b_pipe_valid@%0d", rel), b_pipe_valid, rel == 3);
            if (rel == 3) check("b_pipe_counter", b_pipe_counter, mem[base]);
            check($sformatf("b_pipe_clear@%0d", rel), b_pipe_clear, rel == 4);
            check($sformatf("b_done@%0d", rel), b_done, rel == 5);
            check($sformatf("b_busy@%0d", rel), b_busy, rel <= 5);
            check($sformatf("b_row_flags@%0d", rel), b_row_flags, (rel >= 4) ? res : 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; pm_restart = 1'b0;
        b_start = 1'b0; b_abort = 1'b0; b_base = '0; b_pipe_result = 1'b0;
        pat = 4'b0000;
        fill_mem(1'b1);
        repeat (3) tick();
        check("reset_busy", busy, 1'b0);
        check("reset_mem_rd", mem_rd, 1'b0);
        check("reset_pipe_valid", pipe_valid, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_row_flags", row_flags, '0);
        check("reset_b_busy", b_busy, 1'b0);
        rst = 1'b0;
        tick();

        // Basic command, memory word = address.
        pat = 4'b1010;
        run_cmd(8'h10, 0, 0, 0);
        check("basic_row_flags", row_flags, 4'b1010);

        // Address wrap across the top of memory.
        fill_mem(1'b0);
        pat = 4'($urandom);
        run_cmd(8'hF8, 0, 0, 0);

        // Abort on the 5th fetch cycle of row 2.
        pat = 4'b1111;
        run_cmd(8'($urandom), 1 + 2 * ROW_CYC + 4, 0, 0);
        check("abort_row_flags", row_flags, 4'b0011);

        // Start and Abort together in idle: nothing happens.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("collide_idle_busy@%0d", i), busy, 1'b0);
            check($sformatf("collide_idle_rd@%0d", i), mem_rd, 1'b0);
            tick();
        end

        // Start pulse while busy is ignored.
        fill_mem(1'b1);
        pat = 4'b1010;
        run_cmd(8'h10, 0, 20, 0);

        // Reset in the middle of row 1's drain, then a clean basic command.
        run_cmd(8'h10, 0, 0, 30);
        run_cmd(8'h10, 0, 0, 0);
        check("post_reset_row_flags", row_flags, 4'b1010);

        // Randomized commands, some aborted mid-fetch.
        for (int n = 0; n < 4; n++) begin
            int a;
            fill_mem(1'b0);
            pat = 4'($urandom);
            a = ($urandom_range(0, 1) == 1)
                ? 1 + int'($urandom_range(0, NR - 1)) * ROW_CYC + int'($urandom_range(0, NC - 1))
                : 0;
            run_cmd(AW'($urandom), a, 0, 0);
        end

        // Single-row, single-counter, zero-latency instance.
        run_single(1'b1);
        run_single(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
